// File: rtl/sss_rom_arb_if.sv
// sss_rom_arb_if: request, ROM-port and return-data signals of the two-requester SSS ROM arbiter.
interface sss_rom_arb_if #(
    parameter int pDAT_W = 4,
    parameter int pLEN_W = 10
);
    logic              ireq0;
    logic              ireq1;
    logic [10:0]       ibase0;
    logic [10:0]       ibase1;
    logic [pLEN_W-1:0] ilen0;
    logic [pLEN_W-1:0] ilen1;
    logic              ogrant0;
    logic              ogrant1;
    logic              iabort;
    logic              orom_val;
    logic [10:0]       orom_addr;
    logic [pDAT_W-1:0] irom_dat;
    logic              oval;
    logic [pDAT_W-1:0] odat;
    logic              oid;
    logic              olast;
    logic              obusy;

    modport slave (
        input  ireq0, ireq1, ibase0, ibase1, ilen0, ilen1, iabort, irom_dat,
        output ogrant0, ogrant1, orom_val, orom_addr, oval, odat, oid, olast, obusy
    );
    modport master (
        output ireq0, ireq1, ibase0, ibase1, ilen0, ilen1, iabort, irom_dat,
        input  ogrant0, ogrant1, orom_val, orom_addr, oval, odat, oid, olast, obusy
    );
endinterface

// File: rtl/sss_rom_arb.sv
// sss_rom_arb: round-robin two-requester burst arbiter in front of a 1-cycle-latency SSS ROM.
module sss_rom_arb #(
    parameter int pDAT_W   = 4,
    parameter int pDAT_Num = 1024,
    parameter int pLEN_W   = 10
) (
    input logic iclk,
    input logic irst,
    sss_rom_arb_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state, state_nx;
    logic [10:0]       addr;
    logic [pLEN_W-1:0] cnt;
    logic              owner;
    logic              fin, gnt_en, pick0, pick1, take, rom_val;

    // owner doubles as the round-robin pointer; it resets to 1 so requester 0 wins first
    always_comb begin
        fin      = state == RUN && cnt == '0;
        rom_val  = state == RUN && !bus.iabort;
        gnt_en   = !irst && (state == IDLE || (fin && !bus.iabort));
        pick0    = bus.ireq0 && (!bus.ireq1 || owner);
        pick1    = bus.ireq1 && !pick0;
        take     = gnt_en && (pick0 || pick1);
        state_nx = state;
        if (state == RUN && (bus.iabort || fin))
            state_nx = IDLE;
        if (take)
            state_nx = RUN;
    end

    always_ff @(posedge iclk or posedge irst)
        if (irst)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge iclk or posedge irst)
        if (irst) begin
            addr      <= '0;
            cnt       <= '0;
            owner     <= 1'b1;
            bus.oval  <= 1'b0;
            bus.oid   <= 1'b0;
            bus.olast <= 1'b0;
        end else begin
            bus.oval  <= rom_val;
            bus.oid   <= rom_val && owner;
            bus.olast <= rom_val && fin;
            if (take) begin
                addr  <= 11'((pick0 ? bus.ibase0 : bus.ibase1) % pDAT_Num);
                cnt   <= pick0 ? bus.ilen0 : bus.ilen1;
                owner <= pick1;
            end else if (rom_val) begin
                addr <= addr == 11'(pDAT_Num - 1) ? '0 : addr + 11'd1;
                cnt  <= cnt - pLEN_W'(1);
            end
        end

    assign bus.ogrant0   = gnt_en && pick0;
    assign bus.ogrant1   = gnt_en && pick1;
    assign bus.orom_val  = rom_val;
    assign bus.orom_addr = addr;
    assign bus.obusy     = state == RUN;
    assign bus.odat      = irst ? '0 : bus.irom_dat;
endmodule
